// File: rtl/ic_refill_resp.sv
// ic_refill_resp: L2-side responder that fetches a 4-word line from memory and
// hands it to the icache, holding it until the icache completes or HOLD_MAX expires.
module ic_refill_resp #(
  parameter int HOLD_MAX = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         irq,
  input  logic [31:0]  l2_addr,
  input  logic         l2_cache_rw,
  input  logic         complete,
  output logic         l2_busy,
  output logic         l2_rdy,
  output logic [127:0] data_wd_l2,
  output logic         data_wd_l2_en,
  output logic         mem_wr_ic_en,
  output logic         mem_rd_req,
  output logic [31:0]  mem_addr,
  input  logic         mem_ack,
  input  logic [31:0]  mem_rd_data
);
  localparam int WW = $clog2(HOLD_MAX + 1);
  typedef enum logic [1:0] {IDLE, FETCH, FILL, WAIT_CMP} state_t;
  state_t         state;
  logic [31:0]    base;
  logic [1:0]     beat;
  logic [127:0]   line;
  logic [WW-1:0]  wait_cnt;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      base          <= '0;
      beat          <= '0;
      line          <= '0;
      wait_cnt      <= '0;
      l2_busy       <= 1'b0;
      l2_rdy        <= 1'b0;
      data_wd_l2    <= '0;
      data_wd_l2_en <= 1'b0;
      mem_wr_ic_en  <= 1'b0;
      mem_rd_req    <= 1'b0;
      mem_addr      <= '0;
    end else begin
      data_wd_l2_en <= 1'b0;
      mem_wr_ic_en  <= 1'b0;
      case (state)
        IDLE: if (irq && !l2_cache_rw) begin
          base       <= {l2_addr[31:4], 4'b0};
          mem_addr   <= {l2_addr[31:4], 4'b0};
          beat       <= '0;
          line       <= '0;
          l2_busy    <= 1'b1;
          mem_rd_req <= 1'b1;
          state      <= FETCH;
        end
        FETCH: if (mem_ack) begin
          line[{beat, 5'd0} +: 32] <= mem_rd_data;
          beat     <= beat + 2'd1;
          mem_addr <= base + {28'b0, beat + 2'd1, 2'b0};
          if (beat == 2'd3) begin
            mem_rd_req <= 1'b0;
            state      <= FILL;
          end
        end
        FILL: if (complete) begin
          l2_busy <= 1'b0;
          state   <= IDLE;
        end else begin
          data_wd_l2    <= line;
          data_wd_l2_en <= 1'b1;
          mem_wr_ic_en  <= 1'b1;
          l2_rdy        <= 1'b1;
          wait_cnt      <= '0;
          state         <= WAIT_CMP;
        end
        WAIT_CMP: if (complete || wait_cnt == WW'(HOLD_MAX - 1)) begin
          l2_rdy   <= 1'b0;
          l2_busy  <= 1'b0;
          wait_cnt <= '0;
          state    <= IDLE;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ic_refill_resp.sv
// tb_ic_refill_resp: directed bench with an address/line scoreboard for ic_refill_resp.
module tb_ic_refill_resp;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         irq = 1'b0;
  logic [31:0]  l2_addr = '0;
  logic         l2_cache_rw = 1'b0;
  logic         complete = 1'b0;
  logic         l2_busy, l2_rdy, data_wd_l2_en, mem_wr_ic_en, mem_rd_req;
  logic [127:0] data_wd_l2;
  logic [31:0]  mem_addr;
  logic         mem_ack = 1'b0;
  logic [31:0]  mem_rd_data = '0;
  int tests = 0;
  int fails = 0;
  logic [31:0]  addr_q[$];
  logic [31:0]  word_q[$];
  logic [127:0] line_q[$];

  ic_refill_resp #(.HOLD_MAX(16)) dut (
    .clk(clk), .rst(rst), .irq(irq), .l2_addr(l2_addr), .l2_cache_rw(l2_cache_rw),
    .complete(complete), .l2_busy(l2_busy), .l2_rdy(l2_rdy), .data_wd_l2(data_wd_l2),
    .data_wd_l2_en(data_wd_l2_en), .mem_wr_ic_en(mem_wr_ic_en), .mem_rd_req(mem_rd_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, l2_busy, 0);
    chk({tag, "_rdy"}, l2_rdy, 0);
    chk({tag, "_en"}, data_wd_l2_en, 0);
    chk({tag, "_wr_ic"}, mem_wr_ic_en, 0);
    chk({tag, "_req"}, mem_rd_req, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_data"}, data_wd_l2, 0);
  endtask

  // One read refill: dly wait cycles before each ack; irq_fetch drives irq high during FETCH.
  task automatic refill(input logic [31:0] a, input int dly, input bit cmp, input bit irq_fetch);
    logic [127:0] ln;
    logic [31:0]  w;
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      word_q.push_back(w);
      addr_q.push_back({a[31:4], 4'b0} + 32'(4 * i));
      ln[32*i +: 32] = w;
    end
    line_q.push_back(ln);
    irq = 1'b1; l2_cache_rw = 1'b0; l2_addr = a;
    tick();
    irq = irq_fetch;
    chk("busy_fetch", l2_busy, 1);
    for (int i = 0; i < 4; i++) begin
      for (int d = 0; d < dly; d++) begin
        chk("req_wait", mem_rd_req, 1);
        chk("addr_wait", mem_addr, addr_q[0]);
        tick();
      end
      chk("req", mem_rd_req, 1);
      chk("addr", mem_addr, addr_q.pop_front());
      mem_ack = 1'b1;
      mem_rd_data = word_q.pop_front();
      tick();
      mem_ack = 1'b0;
    end
    irq = 1'b0;
    chk("fill_req", mem_rd_req, 0);
    chk("fill_en", data_wd_l2_en, 0);
    chk("fill_busy", l2_busy, 1);
    tick();
    chk("strobe_en", data_wd_l2_en, 1);
    chk("strobe_wr_ic", mem_wr_ic_en, 1);
    chk("strobe_rdy", l2_rdy, 1);
    chk("strobe_data", data_wd_l2, line_q[0]);
    tick();
    chk("wait_en", data_wd_l2_en, 0);
    chk("wait_wr_ic", mem_wr_ic_en, 0);
    chk("wait_rdy", l2_rdy, 1);
    chk("wait_data", data_wd_l2, line_q.pop_front());
    if (cmp) begin
      complete = 1'b1;
      tick();
      complete = 1'b0;
      chk("done_busy", l2_busy, 0);
      chk("done_rdy", l2_rdy, 0);
    end
  endtask

  initial begin
    int n;
    logic [127:0] last;
    repeat (2) tick();
    chk_all_zero("reset");
    rst = 1'b1;
    tick();

    // zero-wait memory at 0x1234
    refill(32'h0000_1234, 0, 1'b1, 1'b0);
    last = data_wd_l2;
    complete = 1'b1;
    tick();
    complete = 1'b0;
    chk("idle_complete_busy", l2_busy, 0);
    chk("idle_retain_data", data_wd_l2, last);

    // write requests are ignored
    irq = 1'b1; l2_cache_rw = 1'b1; l2_addr = 32'h0000_9990;
    repeat (3) begin
      tick();
      chk("wr_busy", l2_busy, 0);
      chk("wr_req", mem_rd_req, 0);
    end
    irq = 1'b0; l2_cache_rw = 1'b0;

    // three-cycle ack latency
    refill(32'hABCD_EF08, 3, 1'b1, 1'b0);

    // irq pulsed during FETCH and dropped before IDLE is ignored
    refill(32'h0000_5000, 0, 1'b1, 1'b1);
    tick();
    chk("ignored_irq_busy", l2_busy, 0);
    chk("ignored_irq_req", mem_rd_req, 0);

    // timeout without complete
    refill(32'h0000_7770, 0, 1'b0, 1'b0);
    n = 2;
    for (int k = 0; k < 40 && l2_rdy; k++) begin
      tick();
      if (l2_rdy) n++;
    end
    chk("hold_cycles", n, 16);
    chk("timeout_busy", l2_busy, 0);

    // irq still high at completion is serviced from IDLE
    refill(32'h0000_3000, 0, 1'b0, 1'b1);
    irq = 1'b1; l2_addr = 32'h0000_4444; complete = 1'b1;
    tick();
    complete = 1'b0;
    chk("pend_idle_busy", l2_busy, 0);
    tick();
    irq = 1'b0;
    chk("pend_busy", l2_busy, 1);
    chk("pend_req", mem_rd_req, 1);
    chk("pend_addr", mem_addr, 32'h0000_4440);
    rst = 1'b0;
    tick();
    rst = 1'b1;

    // reset during beat 2 abandons the refill
    irq = 1'b1; l2_addr = 32'h0000_6010;
    tick();
    irq = 1'b0;
    mem_ack = 1'b1; mem_rd_data = 32'h1111_1111;
    tick();
    mem_rd_data = 32'h2222_2222;
    tick();
    mem_ack = 1'b0;
    chk("beat2_addr", mem_addr, 32'h0000_6018);
    chk("beat2_req", mem_rd_req, 1);
    rst = 1'b0;
    tick();
    chk_all_zero("midreset");
    rst = 1'b1;
    repeat (4) begin
      tick();
      chk("post_reset_en", data_wd_l2_en, 0);
      chk("post_reset_busy", l2_busy, 0);
    end
    refill(32'h0000_6010, 2, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ic_refill_resp.md
IC_REFILL_RESP -- requirements
Module: ic_refill_resp

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 16: max cycles in WAIT_CMP before abandoning a refill.
REQ-002 SHALL have ports, in this order:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-low reset.
- irq  in  1  icache refill request.
- l2_addr  in  32  miss address from icache.
- l2_cache_rw  in  1  request type; 0 = READ, 1 = WRITE.
- complete  in  1  icache has written the line into L1.
- l2_busy  out  1  responder is servicing a request.
- l2_rdy  out  1  refill line valid on data_wd_l2.
- data_wd_l2  out  128  refill line.
- data_wd_l2_en  out  1  one-cycle line-write strobe.
- mem_wr_ic_en  out  1  one-cycle icache write enable, coincident with data_wd_l2_en.
- mem_rd_req  out  1  memory word-read request.
- mem_addr  out  32  memory word address.
- mem_ack  in  1  memory read data valid this cycle.
- mem_rd_data  in  32  memory read word.
REQ-003 SHALL register all outputs; no combinational input-to-output paths.

Function
REQ-004 SHALL implement states IDLE, FETCH, FILL and WAIT_CMP.
REQ-005 IDLE, irq=1 and l2_cache_rw=0: SHALL latch base={l2_addr[31:4],4'b0}, clear beat counter and line buffer, and enter FETCH next cycle.
REQ-006 IDLE, irq=1 and l2_cache_rw=1: SHALL ignore the request and stay in IDLE with outputs unchanged.
REQ-007 SHALL set l2_busy=1 in FETCH, FILL and WAIT_CMP, and 0 in IDLE.
REQ-008 SHALL ignore irq while l2_busy=1; a pending irq is serviced only when sampled in IDLE.
REQ-009 FETCH:
- mem_rd_req=1, mem_addr=base+4*beat, beat = 2-bit counter 0..3.
- mem_rd_req and mem_addr SHALL be held stable until mem_ack=1.
REQ-010 FETCH, mem_ack=1: SHALL store mem_rd_data into line[32*beat+31:32*beat] and increment beat.
REQ-011 FETCH, mem_ack=1 with beat=3: SHALL drop mem_rd_req and enter FILL; beat wraps to 0.
REQ-012 SHALL ignore mem_ack outside FETCH.
REQ-013 FILL lasts exactly one cycle:
- data_wd_l2_en=1, mem_wr_ic_en=1, l2_rdy=1, data_wd_l2=line.
- then enter WAIT_CMP.
REQ-014 WAIT_CMP: SHALL hold l2_rdy=1 and data_wd_l2 stable, with data_wd_l2_en=0 and mem_wr_ic_en=0.
REQ-015 complete=1 in FILL or WAIT_CMP: SHALL enter IDLE next cycle with l2_rdy=0 and l2_busy=0.
REQ-016 WAIT_CMP wait counter:
- SHALL count cycles in WAIT_CMP.
- After HOLD_MAX cycles without complete, SHALL enter IDLE exactly as in REQ-015.
REQ-017 complete in IDLE or FETCH: SHALL have no effect.
REQ-018 Zero-wait memory (mem_ack=1 every FETCH cycle), irq sampled at edge 0: SHALL give FETCH at edges 1-4 and data_wd_l2_en=1 in the cycle after edge 5.
REQ-019 In IDLE, data_wd_l2 SHALL retain the last line; its value is don't-care when l2_rdy=0.

Reset
REQ-020 rst=0 at a rising edge, in any state: SHALL force IDLE and set:
- l2_busy, l2_rdy, data_wd_l2_en, mem_wr_ic_en, mem_rd_req = 0.
- mem_addr, data_wd_l2, line buffer, beat and wait counters = 0.
REQ-021 Reset mid-FETCH or mid-WAIT_CMP: SHALL abandon the refill; no later data_wd_l2_en for that request.

Verification
REQ-022 l2_addr=0x0000_1234, READ, zero-wait memory returning words A0..A3:
- mem_addr = 0x1230, 0x1234, 0x1238, 0x123C.
- data_wd_l2={A3,A2,A1,A0}; single-cycle data_wd_l2_en; complete -> l2_busy=0 next cycle.
REQ-023 mem_ack delayed 3 cycles per beat: mem_rd_req/mem_addr held each wait; line assembled correctly; FILL after 16 FETCH cycles.
REQ-024 irq with l2_cache_rw=1: no mem_rd_req, l2_busy stays 0.
REQ-025 Second irq during FETCH: ignored; serviced only if still high in IDLE after completion.
REQ-026 complete never asserted, HOLD_MAX=16: l2_rdy drops and state returns to IDLE after 16 WAIT_CMP cycles.
REQ-027 rst=0 during beat 2 of FETCH: all outputs 0 next cycle; a following new request fetches from beat 0.
